// File: rtl/beat_clock_ctrl.sv
// beat_clock_ctrl: transport controller for the step sequencer.
// Converts the tempo period into beat/measure pulses and tracks the
// STOP/RUN/PAUSE transport state and the step index within a measure.
// Optional feature macro: BEAT_SWING_EN. When it is defined, intervals that
// start at an even step are lengthened by period_lat>>2 cycles.
module beat_clock_ctrl #(
  parameter int STEPS  = 8,
  parameter int STEP_W = 3,
  parameter int CNT_W  = 23
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              play_button,
  input  logic              stop_button,
  input  logic [CNT_W-1:0]  tempo,
  output logic              beat_pulse,
  output logic              measure_pulse,
  output logic [STEP_W-1:0] step,
  output logic              playing
);

`ifdef BEAT_SWING_EN
  // Swing terminals can exceed period_lat, so the counter carries one extra bit.
  localparam int CNT_IW = CNT_W + 1;
`else
  localparam int CNT_IW = CNT_W;
`endif

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_IW-1:0]   count_q, count_d;
  logic [CNT_W-1:0]    period_lat_q, period_lat_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                beat_pulse_q, beat_pulse_d;
  logic                measure_pulse_q, measure_pulse_d;
  logic                playing_q, playing_d;

  logic [CNT_IW-1:0]   term_s;
  logic                at_term_s;
  logic [STEP_W-1:0]   step_next_s;

`ifdef BEAT_SWING_EN
  // Terminal count for the current interval: even steps get a quarter-period swing.
  always_comb begin
    if (step_q[0] == 1'b0) begin
      term_s = {1'b0, period_lat_q} + ({1'b0, period_lat_q} >> 2);
    end else begin
      term_s = {1'b0, period_lat_q};
    end
  end
`else
  // Terminal count for the current interval: always the latched period.
  always_comb begin
    term_s = period_lat_q;
  end
`endif

  assign at_term_s   = (count_q == term_s);
  assign step_next_s = (step_q == STEP_W'(STEPS - 1)) ? {STEP_W{1'b0}} : (step_q + STEP_W'(1));

  // Next-state logic for the transport FSM, beat counter and step index.
  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    period_lat_d    = period_lat_q;
    step_d          = step_q;
    beat_pulse_d    = 1'b0;
    measure_pulse_d = 1'b0;
    if (stop_button) begin
      // Stop wins over play; the latched period is kept until the next start.
      state_d = ST_STOP;
      count_d = {CNT_IW{1'b0}};
      step_d  = {STEP_W{1'b0}};
    end else begin
      case (state_q)
        ST_STOP: begin
          if (play_button) begin
            state_d         = ST_RUN;
            count_d         = {CNT_IW{1'b0}};
            step_d          = {STEP_W{1'b0}};
            period_lat_d    = tempo;
            beat_pulse_d    = 1'b1;
            measure_pulse_d = 1'b1;
          end else begin
            count_d = {CNT_IW{1'b0}};
            step_d  = {STEP_W{1'b0}};
          end
        end
        ST_RUN: begin
          if (play_button) begin
            // Pausing freezes count/step, even if this was a terminal cycle.
            state_d = ST_PAUSE;
          end else if (at_term_s) begin
            count_d         = {CNT_IW{1'b0}};
            step_d          = step_next_s;
            period_lat_d    = tempo;
            beat_pulse_d    = 1'b1;
            measure_pulse_d = (step_next_s == {STEP_W{1'b0}});
          end else begin
            count_d = count_q + CNT_IW'(1);
          end
        end
        ST_PAUSE: begin
          if (play_button) begin
            // Resume from the frozen count without re-sampling tempo.
            state_d = ST_RUN;
          end else begin
            state_d = ST_PAUSE;
          end
        end
        default: begin
          state_d = ST_STOP;
          count_d = {CNT_IW{1'b0}};
          step_d  = {STEP_W{1'b0}};
        end
      endcase
    end
    playing_d = (state_d == ST_RUN);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q         <= ST_STOP;
      count_q         <= {CNT_IW{1'b0}};
      period_lat_q    <= {CNT_W{1'b0}};
      step_q          <= {STEP_W{1'b0}};
      beat_pulse_q    <= 1'b0;
      measure_pulse_q <= 1'b0;
      playing_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      period_lat_q    <= period_lat_d;
      step_q          <= step_d;
      beat_pulse_q    <= beat_pulse_d;
      measure_pulse_q <= measure_pulse_d;
      playing_q       <= playing_d;
    end
  end

  assign beat_pulse    = beat_pulse_q;
  assign measure_pulse = measure_pulse_q;
  assign step          = step_q;
  assign playing       = playing_q;

endmodule
